// File: rtl/line_mem_responder_pkg.sv
// Shared definitions for the line memory responder.
//   state_t : transaction FSM states (IDLE -> WAIT -> BURST -> DONE -> IDLE)
//   op_t    : latched operation kind (refill read / write-back)
//   WORD_W  : width of one RAM word and one line word
package line_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    localparam int WORD_W = 32;

endpackage

// File: rtl/line_mem_ram.sv
// Single-port synchronous word RAM with a one-cycle read.
// Ports:
//   clk   : clock
//   en    : access enable (read or write this cycle)
//   we    : write enable for the addressed word (qualified by en)
//   addr  : word address
//   wdata : write data
//   rdata : read data, valid the cycle after a read access
// Contents are not reset.
module line_mem_ram #(
    parameter int AW = 13,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/line_mem_responder.sv
// Main-memory responder for data-cache line refills and dirty-line write-backs.
// A request is accepted in IDLE, waits LATENCY cycles, then moves one word per
// cycle through a word-wide RAM and pulses gnt for one cycle.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   rd_req / wr_req    : level requests, held until gnt; wr_req wins when both are high
//   rd_addr / wr_addr  : line addresses for refill / write-back
//   wr_line            : write-back data, word i at [32i+31:32i]
//   rd_line            : refill data, complete in the gnt cycle, held until the next refill
//   gnt                : one-cycle completion pulse
//   busy               : high from acceptance through the gnt cycle
//   rd_count/wr_count  : completed refills / write-backs since reset
//   state_dbg          : current FSM state
// Handshake: a request is accepted on the rising edge that ends an IDLE cycle in
// which rd_req or wr_req is high; the requester drops it on the edge ending gnt.
module line_mem_responder
    import line_mem_responder_pkg::*;
#(
    parameter int LINE_ADDR_LEN = 3,
    parameter int MEM_ADDR_LEN  = 10,
    parameter int LATENCY       = 50
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  rd_req,
    input  logic                                  wr_req,
    input  logic [MEM_ADDR_LEN-1:0]               rd_addr,
    input  logic [MEM_ADDR_LEN-1:0]               wr_addr,
    input  logic [WORD_W*(2**LINE_ADDR_LEN)-1:0]  wr_line,
    output logic [WORD_W*(2**LINE_ADDR_LEN)-1:0]  rd_line,
    output logic                                  gnt,
    output logic                                  busy,
    output logic [31:0]                           rd_count,
    output logic [31:0]                           wr_count,
    output logic [1:0]                            state_dbg
);

    localparam int WORDS  = 2**LINE_ADDR_LEN;
    localparam int LINE_W = WORD_W * WORDS;
    localparam int RAM_AW = MEM_ADDR_LEN + LINE_ADDR_LEN;
    localparam int LAT_W  = $clog2(LATENCY + 1);

    state_t                  state, state_nxt;
    op_t                     op_q;
    logic [MEM_ADDR_LEN-1:0] addr_q;
    logic [LINE_W-1:0]       wline_q;
    logic [LAT_W-1:0]        lat_q;
    // One bit wider than a word index so reads can run one extra drain cycle
    // (k == WORDS) without touching the next line.
    logic [LINE_ADDR_LEN:0]  k_q;
    logic [LINE_ADDR_LEN-1:0] k_idx;
    logic [LINE_ADDR_LEN-1:0] k_prev;
    logic                    burst_last;

    logic                    ram_en;
    logic                    ram_we;
    logic [RAM_AW-1:0]       ram_addr;
    logic [WORD_W-1:0]       ram_wdata;
    logic [WORD_W-1:0]       ram_rdata;

    assign k_idx  = k_q[LINE_ADDR_LEN-1:0];
    assign k_prev = LINE_ADDR_LEN'(k_q - 1'b1);

    // Writes finish on the last word; reads need one more cycle for the
    // final RAM read to land.
    assign burst_last = (op_q == OP_WR) ? (k_q == (LINE_ADDR_LEN+1)'(WORDS - 1))
                                        : (k_q == (LINE_ADDR_LEN+1)'(WORDS));

    assign ram_en    = (state == ST_BURST) && !k_q[LINE_ADDR_LEN];
    assign ram_we    = ram_en && (op_q == OP_WR);
    assign ram_addr  = {addr_q, k_idx};
    assign ram_wdata = wline_q[WORD_W*k_idx +: WORD_W];

    assign gnt       = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (wr_req || rd_req) state_nxt = ST_WAIT;
            ST_WAIT:  if (lat_q == LAT_W'(LATENCY - 1)) state_nxt = ST_BURST;
            ST_BURST: if (burst_last) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= OP_RD;
            addr_q   <= '0;
            wline_q  <= '0;
            lat_q    <= '0;
            k_q      <= '0;
            rd_line  <= '0;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wr_req) begin
                        op_q   <= OP_WR;
                        addr_q <= wr_addr;
                    end else if (rd_req) begin
                        op_q   <= OP_RD;
                        addr_q <= rd_addr;
                    end
                    wline_q <= wr_line;
                    lat_q   <= '0;
                    k_q     <= '0;
                end
                ST_WAIT: begin
                    lat_q <= lat_q + 1'b1;
                end
                ST_BURST: begin
                    k_q <= k_q + 1'b1;
                    // Data read for word k-1 is on ram_rdata during cycle k.
                    if (op_q == OP_RD && k_q != '0) begin
                        rd_line[WORD_W*k_prev +: WORD_W] <= ram_rdata;
                    end
                end
                ST_DONE: begin
                    if (op_q == OP_WR) begin
                        wr_count <= wr_count + 1'b1;
                    end else begin
                        rd_count <= rd_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    line_mem_ram #(
        .AW (RAM_AW),
        .DW (WORD_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_line_mem_responder.sv
module tb_line_mem_responder;
  import line_mem_responder_pkg::*;

  localparam int LAT   = 4;
  localparam int LAL   = 3;
  localparam int MAL   = 10;
  localparam int WORDS = 2**LAL;
  localparam int W     = 32 * WORDS;

  logic           clk;
  logic           rst;
  logic           rd_req;
  logic           wr_req;
  logic [MAL-1:0] rd_addr;
  logic [MAL-1:0] wr_addr;
  logic [W-1:0]   wr_line;
  logic [W-1:0]   rd_line;
  logic           gnt;
  logic           busy;
  logic [31:0]    rd_count;
  logic [31:0]    wr_count;
  logic [1:0]     state_dbg;

  line_mem_responder #(
    .LINE_ADDR_LEN (LAL),
    .MEM_ADDR_LEN  (MAL),
    .LATENCY       (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_req    (rd_req),
    .wr_req    (wr_req),
    .rd_addr   (rd_addr),
    .wr_addr   (wr_addr),
    .wr_line   (wr_line),
    .rd_line   (rd_line),
    .gnt       (gnt),
    .busy      (busy),
    .rd_count  (rd_count),
    .wr_count  (wr_count),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model + scoreboard ----------------
  logic [W-1:0] model_mem [0:(2**MAL)-1];
  logic [W-1:0] exp_q[$];
  int unsigned  exp_rd_cnt;
  int unsigned  exp_wr_cnt;
  int           n_cmp;
  int           n_mis;

  function automatic logic [W-1:0] mk_line(input logic [31:0] base);
    logic [W-1:0] l;
    for (int i = 0; i < WORDS; i++) l[32*i +: 32] = base + 32'(i);
    return l;
  endfunction

  function automatic logic [W-1:0] rand_line();
    logic [W-1:0] l;
    for (int i = 0; i < WORDS; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  function automatic int exp_latency(input bit is_wr);
    return 1 + LAT + WORDS + (is_wr ? 0 : 1);
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle. Returns cycles from acceptance to gnt
  // (0 if gnt never came) and rd_line sampled in the gnt cycle. Returns at the
  // negedge of the cycle after gnt.
  task automatic run_txn(input bit is_wr, input logic [MAL-1:0] addr, input logic [W-1:0] line,
                         input bit early_drop, output int lat, output logic [W-1:0] got);
    if (is_wr) begin
      wr_req = 1'b1; wr_addr = addr; wr_line = line;
      model_mem[addr] = line;
    end else begin
      rd_req = 1'b1; rd_addr = addr;
    end
    lat = 0;
    got = '0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (early_drop && n == 1) begin
        rd_req = 1'b0; wr_req = 1'b0;
        wr_addr = ~addr; rd_addr = ~addr; wr_line = ~line;
      end
      if (gnt) begin
        lat = n;
        got = rd_line;
        break;
      end
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    if (is_wr) exp_wr_cnt++; else exp_rd_cnt++;
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          is_wr;
    logic [9:0]  addr;
    logic [31:0] base;     // write: data base; read: expected data base
  } vec_t;

  vec_t         vecs [0:9];
  int           lat;
  logic [W-1:0] got;
  logic [W-1:0] exp_line;
  int           pool [0:3];
  int           gnt_seen;

  initial begin
    n_cmp = 0; n_mis = 0;
    exp_rd_cnt = 0; exp_wr_cnt = 0;
    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_line = '0;

    vecs[0] = '{1'b1, 10'd5,    32'h0000_0100};
    vecs[1] = '{1'b0, 10'd5,    32'h0000_0100};
    vecs[2] = '{1'b1, 10'd0,    32'h0000_A000};
    vecs[3] = '{1'b1, 10'd1023, 32'h0000_B000};
    vecs[4] = '{1'b0, 10'd0,    32'h0000_A000};
    vecs[5] = '{1'b0, 10'd1023, 32'h0000_B000};
    vecs[6] = '{1'b1, 10'd2,    32'h0000_0200};
    vecs[7] = '{1'b1, 10'd5,    32'h0000_C000};
    vecs[8] = '{1'b0, 10'd5,    32'h0000_C000};
    vecs[9] = '{1'b0, 10'd2,    32'h0000_0200};
    pool[0] = 0; pool[1] = 2; pool[2] = 5; pool[3] = 1023;

    repeat (3) @(negedge clk);
    chk("reset_gnt", gnt, 0);
    chk("reset_busy", busy, 0);
    chk("reset_state", state_dbg, ST_IDLE);
    chk("reset_rd_line", rd_line, 0);
    chk("reset_counts", {rd_count, wr_count}, 0);
    rst = 1'b0;
    @(negedge clk);

    // table-driven vectors
    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].is_wr, vecs[i].addr, mk_line(vecs[i].base), 1'b0, lat, got);
      chk($sformatf("vec%0d_latency", i), lat, exp_latency(vecs[i].is_wr));
      if (!vecs[i].is_wr) chk($sformatf("vec%0d_rd_line", i), got, mk_line(vecs[i].base));
      chk($sformatf("vec%0d_busy_after", i), {gnt, busy}, 0);
      chk($sformatf("vec%0d_counts", i), {rd_count, wr_count}, {exp_rd_cnt, exp_wr_cnt});
    end

    // randomized traffic against the model
    for (int i = 0; i < 30; i++) begin
      bit       is_wr;
      bit       drop;
      logic [MAL-1:0] a;
      is_wr = 1'($urandom_range(0, 1));
      drop  = 1'($urandom_range(0, 1));
      a     = MAL'(pool[$urandom_range(0, 3)]);
      if (!is_wr) exp_q.push_back(model_mem[a]);
      run_txn(is_wr, a, rand_line(), drop, lat, got);
      chk($sformatf("rnd%0d_latency", i), lat, exp_latency(is_wr));
      if (!is_wr) begin
        exp_line = exp_q.pop_front();
        chk($sformatf("rnd%0d_rd_line", i), got, exp_line);
      end
      chk($sformatf("rnd%0d_counts", i), {rd_count, wr_count}, {exp_rd_cnt, exp_wr_cnt});
    end

    // reset in the middle of a write-back burst
    wr_req = 1'b1; wr_addr = 10'd7; wr_line = mk_line(32'hDEAD_0000);
    repeat (7) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_gnt", gnt, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_state", state_dbg, ST_IDLE);
    chk("midrst_counts", {rd_count, wr_count}, 0);
    wr_req = 1'b0;
    exp_rd_cnt = 0; exp_wr_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // simultaneous requests: write line 3 first, then read line 2
    wr_req = 1'b1; wr_addr = 10'd3; wr_line = mk_line(32'h0000_0300);
    rd_req = 1'b1; rd_addr = 10'd2;
    model_mem[3] = mk_line(32'h0000_0300);
    lat = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (gnt) begin lat = n; break; end
    end
    chk("simul_wr_latency", lat, exp_latency(1'b1));
    wr_req = 1'b0;
    lat = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (gnt) begin lat = n; got = rd_line; break; end
    end
    chk("simul_rd_latency", lat, 1 + exp_latency(1'b0));
    chk("simul_rd_line", got, model_mem[2]);
    rd_req = 1'b0;
    @(negedge clk);
    chk("simul_counts", {rd_count, wr_count}, {32'd1, 32'd1});
    exp_rd_cnt = 1; exp_wr_cnt = 1;

    // request dropped one cycle after acceptance
    run_txn(1'b0, 10'd3, '0, 1'b1, lat, got);
    chk("drop_latency", lat, exp_latency(1'b0));
    chk("drop_rd_line", got, mk_line(32'h0000_0300));
    gnt_seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (gnt || busy) gnt_seen++;
    end
    chk("drop_no_second_txn", gnt_seen, 0);
    chk("drop_counts", {rd_count, wr_count}, {exp_rd_cnt, exp_wr_cnt});

    // line 0 untouched by the earlier write to the top line
    run_txn(1'b1, 10'd1023, mk_line(32'h0000_F000), 1'b0, lat, got);
    run_txn(1'b0, 10'd0, '0, 1'b0, lat, got);
    chk("nowrap_rd_line", got, model_mem[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
